// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Types and constants shared by the program-loader stage and its RAM.
//   loader_state_t    : boot-loader frame state
//   PROG_AW           : program RAM word-address width
//   SYNC_BYTE_DEFAULT : frame start marker
//   is_busy()         : true while a frame is being received
// -----------------------------------------------------------------------------
package cpu_pkg;

  localparam int         PROG_AW           = 10;
  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'h55;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_WAIT_SYNC = 4'd1,
    ST_LEN_LO    = 4'd2,
    ST_LEN_HI    = 4'd3,
    ST_DATA_LO   = 4'd4,
    ST_DATA_HI   = 4'd5,
    ST_CHECK     = 4'd6,
    ST_DONE      = 4'd7,
    ST_ERR       = 4'd8
  } loader_state_t;

  // Frame reception is in progress from the first length byte up to the checksum.
  function automatic logic is_busy(input loader_state_t s);
    logic busy;
    case (s)
      ST_LEN_LO, ST_LEN_HI, ST_DATA_LO, ST_DATA_HI, ST_CHECK: busy = 1'b1;
      default:                                              busy = 1'b0;
    endcase
    return busy;
  endfunction

endpackage

// File: rtl/prog_ram.sv
// -----------------------------------------------------------------------------
// prog_ram
// 2**AW x 16 program RAM: one write port, one synchronous read port,
// read-first on address collision. The array is never reset; only the read
// data register clears so the core sees a defined 16'h0000 out of reset.
//   clk, rst_n : clock, async active-low reset (read register only)
//   we_i       : write enable
//   waddr_i    : write word address
//   wdata_i    : write data
//   raddr_i    : read word address
//   rdata_o    : registered read data (1-cycle latency)
// -----------------------------------------------------------------------------
module prog_ram
  import cpu_pkg::*;
#(
  parameter int AW = PROG_AW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [15:0]   wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [15:0]   rdata_o
);

  logic [15:0] mem_q [0:(2**AW)-1];
  logic [15:0] rdata_q;

  // Write port; kept reset-free so the array maps onto block RAM.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Read port; non-blocking update means a same-cycle write is not yet visible (read-first).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= 16'h0000;
    end else begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/prog_loader.sv
// -----------------------------------------------------------------------------
// prog_loader
// Program-memory stage in front of the CPU core. While boot_mode is high the
// core is held in reset and a framed image is received from the UART:
//   SYNC_BYTE, len_lo, len_hi, n x (data_lo, data_hi), checksum
// Words are written to program RAM; once released, the core fetches by PC.
//   clk, rst_n   : clock, async active-low reset
//   boot_mode    : high = load mode (core held in reset)
//   rx_data      : received byte, valid when rx_valid is high
//   rx_valid     : single-cycle byte strobe
//   pc           : byte PC from core, word address = pc[AW:1]
//   dout         : instruction word, 1-cycle fetch latency
//   cpu_rst_n    : registered active-low core reset
//   load_busy    : frame reception in progress
//   load_done    : last frame passed checksum (sticky until next load)
//   load_err     : last frame failed or was aborted (sticky until next load)
//   words_loaded : words written by the current/last frame
// -----------------------------------------------------------------------------
module prog_loader
  import cpu_pkg::*;
#(
  parameter int         AW          = PROG_AW,
  parameter logic [7:0] SYNC_BYTE   = SYNC_BYTE_DEFAULT,
  parameter int         TIMEOUT_CYC = 27_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        boot_mode,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  input  logic [AW:0] pc,
  output logic [15:0] dout,
  output logic        cpu_rst_n,
  output logic        load_busy,
  output logic        load_done,
  output logic        load_err,
  output logic [AW:0] words_loaded
);

  localparam int          TW        = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TMR_LAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [AW:0] MAX_WORDS = {1'b1, {AW{1'b0}}};

  loader_state_t state_q, state_d;
  logic [7:0]    len_lo_q, len_lo_d;
  logic [AW:0]   len_q, len_d;
  logic [7:0]    lo_q, lo_d;
  logic [7:0]    sum_q, sum_d;
  logic [AW:0]   wl_q, wl_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic          cpu_rst_n_q;
  logic          busy_q;

  logic          we_s;
  logic [15:0]   len_word_s;
  logic [AW:0]   n_s;
  logic [AW:0]   wl_inc_s;
  logic [7:0]    sum_rx_s;
  logic          timeout_s;
  logic          unused_s;

  assign len_word_s = {rx_data, len_lo_q};
  assign n_s        = len_word_s[AW:0];
  assign wl_inc_s   = wl_q + {{AW{1'b0}}, 1'b1};
  assign sum_rx_s   = sum_q + rx_data;
  // The counter value one below the limit means this idle cycle is the one that reaches it.
  assign timeout_s  = (tmr_q == TMR_LAST);
  assign unused_s   = ^{pc[0], len_word_s[15:AW+1]};

  // Next-state, datapath and flag update for the frame receiver.
  always_comb begin
    state_d  = state_q;
    len_lo_d = len_lo_q;
    len_d    = len_q;
    lo_d     = lo_q;
    sum_d    = sum_q;
    wl_d     = wl_q;
    done_d   = done_q;
    err_d    = err_q;
    we_s     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (boot_mode) begin
          state_d = ST_WAIT_SYNC;
          done_d  = 1'b0;
          err_d   = 1'b0;
          wl_d    = '0;
          sum_d   = 8'h00;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT_SYNC: begin
        if (!boot_mode) begin
          state_d = ST_IDLE;
          err_d   = 1'b1;
        end else if (rx_valid && (rx_data == SYNC_BYTE)) begin
          state_d = ST_LEN_LO;
        end else begin
          state_d = ST_WAIT_SYNC;
        end
      end
      ST_LEN_LO, ST_LEN_HI, ST_DATA_LO, ST_DATA_HI, ST_CHECK: begin
        // Abort has priority over a byte arriving in the same cycle.
        if (!boot_mode) begin
          state_d = ST_IDLE;
          err_d   = 1'b1;
        end else if (rx_valid) begin
          sum_d = sum_rx_s;
          case (state_q)
            ST_LEN_LO: begin
              len_lo_d = rx_data;
              state_d  = ST_LEN_HI;
            end
            ST_LEN_HI: begin
              if ((n_s == '0) || (n_s > MAX_WORDS)) begin
                state_d = ST_ERR;
                err_d   = 1'b1;
              end else begin
                len_d   = n_s;
                state_d = ST_DATA_LO;
              end
            end
            ST_DATA_LO: begin
              lo_d    = rx_data;
              state_d = ST_DATA_HI;
            end
            ST_DATA_HI: begin
              // words_loaded doubles as the write address.
              we_s = 1'b1;
              wl_d = wl_inc_s;
              if (wl_inc_s == len_q) begin
                state_d = ST_CHECK;
              end else begin
                state_d = ST_DATA_LO;
              end
            end
            ST_CHECK: begin
              if (sum_rx_s == 8'h00) begin
                state_d = ST_DONE;
                done_d  = 1'b1;
              end else begin
                state_d = ST_ERR;
                err_d   = 1'b1;
              end
            end
            default: begin
              state_d = ST_ERR;
              err_d   = 1'b1;
            end
          endcase
        end else if (timeout_s) begin
          state_d = ST_ERR;
          err_d   = 1'b1;
        end else begin
          state_d = state_q;
        end
      end
      ST_DONE, ST_ERR: begin
        if (!boot_mode) begin
          state_d = ST_IDLE;
        end else begin
          state_d = state_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Inter-byte timer: counts only while busy, restarts on every byte and every state change.
  always_comb begin
    tmr_d = '0;
    if (is_busy(state_q) && !rx_valid && (state_d == state_q)) begin
      tmr_d = tmr_q + {{(TW-1){1'b0}}, 1'b1};
    end else begin
      tmr_d = '0;
    end
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      len_lo_q    <= 8'h00;
      len_q       <= '0;
      lo_q        <= 8'h00;
      sum_q       <= 8'h00;
      wl_q        <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      tmr_q       <= '0;
      cpu_rst_n_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_lo_q    <= len_lo_d;
      len_q       <= len_d;
      lo_q        <= lo_d;
      sum_q       <= sum_d;
      wl_q        <= wl_d;
      done_q      <= done_d;
      err_q       <= err_d;
      tmr_q       <= tmr_d;
      cpu_rst_n_q <= !boot_mode && (state_q == ST_IDLE);
      busy_q      <= is_busy(state_d);
    end
  end

  prog_ram #(
    .AW(AW)
  ) u_ram (
    .clk    (clk),
    .rst_n  (rst_n),
    .we_i   (we_s),
    .waddr_i(wl_q[AW-1:0]),
    .wdata_i({rx_data, lo_q}),
    .raddr_i(pc[AW:1]),
    .rdata_o(dout)
  );

  assign cpu_rst_n    = cpu_rst_n_q;
  assign load_busy    = busy_q;
  assign load_done    = done_q;
  assign load_err     = err_q;
  assign words_loaded = wl_q;

endmodule

// File: tb/tb_prog_loader.sv
module tb_prog_loader;

  localparam int TO = 100;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        boot_mode = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic [10:0] pc = 11'd0;
  logic [15:0] dout;
  logic        cpu_rst_n, load_busy, load_done, load_err;
  logic [10:0] words_loaded;

  always #5 clk = ~clk;

  prog_loader #(.TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst_n(rst_n), .boot_mode(boot_mode), .rx_data(rx_data),
    .rx_valid(rx_valid), .pc(pc), .dout(dout), .cpu_rst_n(cpu_rst_n),
    .load_busy(load_busy), .load_done(load_done), .load_err(load_err),
    .words_loaded(words_loaded)
  );

  int checks = 0;
  int errors = 0;
  bit rand_pc = 1'b0;
  int gap_max = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model (frame position based) ----------------
  // phase: 0 = not loading, 1 = hunting for sync, 2 = inside frame, 3 = finished
  int          m_phase, m_pos, m_len, m_sum, m_lenlo, m_lo, m_wl, m_idle;
  bit          m_done, m_err, m_cpu, m_busy, m_dout_known;
  logic [15:0] m_dout;
  logic [15:0] m_ram [1024];
  bit          m_known [1024];

  task automatic model_reset();
    m_phase = 0; m_pos = 0; m_len = 0; m_sum = 0; m_lenlo = 0; m_lo = 0;
    m_wl = 0; m_idle = 0; m_done = 0; m_err = 0; m_cpu = 0; m_busy = 0;
    m_dout = 16'h0000; m_dout_known = 1;
  endtask

  task automatic model_step();
    int a, n, k, d;
    bit nxt_cpu;
    a = int'(pc[10:1]);
    d = int'(rx_data);
    nxt_cpu = !boot_mode && (m_phase == 0);
    m_dout = m_ram[a];
    m_dout_known = m_known[a];
    if (m_phase == 0) begin
      if (boot_mode) begin
        m_phase = 1; m_done = 0; m_err = 0; m_wl = 0; m_sum = 0;
      end
    end else if (m_phase == 3) begin
      if (!boot_mode) m_phase = 0;
    end else if (!boot_mode) begin
      m_phase = 0; m_err = 1;
    end else if (m_phase == 1) begin
      if (rx_valid && d == 'h55) begin
        m_phase = 2; m_pos = 0; m_idle = 0;
      end
    end else if (rx_valid) begin
      m_idle = 0;
      if (m_pos == 0) begin
        m_lenlo = d; m_sum = (m_sum + d) % 256; m_pos = 1;
      end else if (m_pos == 1) begin
        n = (d * 256 + m_lenlo) % 2048;
        m_sum = (m_sum + d) % 256;
        if (n == 0 || n > 1024) begin
          m_phase = 3; m_err = 1;
        end else begin
          m_len = n; m_pos = 2;
        end
      end else begin
        k = m_pos - 2;
        if (k == 2 * m_len) begin
          m_phase = 3;
          if ((m_sum + d) % 256 == 0) m_done = 1;
          else m_err = 1;
        end else begin
          if (k % 2 == 0) m_lo = d;
          else begin
            m_ram[m_wl] = 16'(d * 256 + m_lo);
            m_known[m_wl] = 1;
            m_wl++;
          end
          m_sum = (m_sum + d) % 256;
          m_pos++;
        end
      end
    end else begin
      m_idle++;
      if (m_idle == TO) begin
        m_phase = 3; m_err = 1;
      end
    end
    m_cpu = nxt_cpu;
    m_busy = (m_phase == 2);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) m_known[i] = 0;
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_step();
    end
  end

  // ---------------- compare process ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (m_dout_known) chk("dout", 32'(dout), 32'(m_dout));
      chk("cpu_rst_n", 32'(cpu_rst_n), 32'(m_cpu));
      chk("load_busy", 32'(load_busy), 32'(m_busy));
      chk("load_done", 32'(load_done), 32'(m_done));
      chk("load_err", 32'(load_err), 32'(m_err));
      chk("words_loaded", 32'(words_loaded), 32'(m_wl));
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #2;
    if (rand_pc) pc = 11'($urandom_range(0, 80));
  endtask

  task automatic send(input logic [7:0] b);
    repeat ($urandom_range(0, gap_max)) cyc();
    rx_data = b;
    rx_valid = 1'b1;
    cyc();
    rx_valid = 1'b0;
    rx_data = 8'($urandom);
  endtask

  task automatic send_list(input logic [7:0] q[$]);
    foreach (q[i]) send(q[i]);
  endtask

  task automatic fetch(input string name, input logic [10:0] a, input logic [15:0] exp);
    pc = a;
    cyc();
    chk(name, 32'(dout), 32'(exp));
  endtask

  logic [15:0] abort_words [3];
  logic [7:0]  fq[$];

  initial begin
    repeat (3) cyc();
    chk("rst_dout", 32'(dout), 32'h0);
    chk("rst_cpu", 32'(cpu_rst_n), 32'h0);
    chk("rst_flags", 32'({load_busy, load_done, load_err}), 32'h0);
    chk("rst_words", 32'(words_loaded), 32'h0);
    rst_n = 1'b1;
    repeat (2) cyc();

    // Checksum-good frame: 02+00+A1+00+90+00 = 33, so CD closes it to zero.
    boot_mode = 1'b1; cyc();
    send_list('{8'h55, 8'h02, 8'h00, 8'hA1, 8'h00, 8'h90, 8'h00, 8'hCD});
    chk("t1_done", 32'(load_done), 32'h1);
    chk("t1_words", 32'(words_loaded), 32'h2);
    boot_mode = 1'b0; cyc();
    chk("t1_cpu_hold", 32'(cpu_rst_n), 32'h0);
    cyc();
    chk("t1_cpu_rel", 32'(cpu_rst_n), 32'h1);
    fetch("t1_w0", 11'd0, 16'h00A1);
    fetch("t1_w1", 11'd2, 16'h0090);
    fetch("t1_pc0_ignored", 11'd3, 16'h0090);

    // Same frame with a wrong checksum byte.
    boot_mode = 1'b1; cyc();
    send_list('{8'h55, 8'h02, 8'h00, 8'hB2, 8'h00, 8'h90, 8'h00, 8'hCE});
    chk("t2_err", 32'({load_done, load_err}), 32'h1);
    boot_mode = 1'b0; repeat (2) cyc();
    fetch("t2_w0", 11'd0, 16'h00B2);

    // Leading junk before sync; sum 01+00+FF+00 = 00.
    boot_mode = 1'b1; cyc();
    send_list('{8'h12, 8'h34, 8'h55, 8'h01, 8'h00, 8'hFF, 8'h00, 8'h00});
    chk("t3_done", 32'({load_done, load_err}), 32'h2);
    chk("t3_words", 32'(words_loaded), 32'h1);
    boot_mode = 1'b0; repeat (2) cyc();
    fetch("t3_w0", 11'd0, 16'h00FF);

    // Zero length.
    boot_mode = 1'b1; cyc();
    send_list('{8'h55, 8'h00, 8'h00});
    chk("t4_err", 32'({load_busy, load_done, load_err}), 32'h1);
    chk("t4_words", 32'(words_loaded), 32'h0);
    boot_mode = 1'b0; repeat (2) cyc();

    // 1029 words exceeds the RAM.
    boot_mode = 1'b1; cyc();
    send_list('{8'h55, 8'h05, 8'h04});
    chk("t5_err", 32'(load_err), 32'h1);
    chk("t5_words", 32'(words_loaded), 32'h0);
    boot_mode = 1'b0; repeat (2) cyc();

    // Timeout after one length byte.
    boot_mode = 1'b1; cyc();
    send_list('{8'h55, 8'h01});
    repeat (TO - 1) cyc();
    chk("t6_still_busy", 32'({load_busy, load_err}), 32'h2);
    cyc();
    chk("t6_timeout", 32'({load_busy, load_err}), 32'h1);
    boot_mode = 1'b0; repeat (2) cyc();

    // Abort after 3 of 10 words.
    boot_mode = 1'b1; cyc();
    send_list('{8'h55, 8'h0A, 8'h00});
    for (int i = 0; i < 3; i++) begin
      abort_words[i] = 16'($urandom);
      send(abort_words[i][7:0]);
      send(abort_words[i][15:8]);
    end
    boot_mode = 1'b0; cyc();
    chk("t7_abort_err", 32'({load_busy, load_done, load_err}), 32'h1);
    chk("t7_words", 32'(words_loaded), 32'h3);
    cyc();
    chk("t7_cpu_rel", 32'(cpu_rst_n), 32'h1);
    for (int i = 0; i < 3; i++) fetch("t7_word", 11'(2 * i), abort_words[i]);

    // Asynchronous reset mid-frame.
    boot_mode = 1'b1; cyc();
    send_list('{8'h55, 8'h03, 8'h00, 8'h11, 8'h22});
    rst_n = 1'b0;
    #1;
    chk("t8_rst_dout", 32'(dout), 32'h0);
    chk("t8_rst_flags", 32'({cpu_rst_n, load_busy, load_done, load_err}), 32'h0);
    chk("t8_rst_words", 32'(words_loaded), 32'h0);
    boot_mode = 1'b0;
    cyc();
    rst_n = 1'b1;
    repeat (2) cyc();
    fetch("t8_kept", 11'd0, 16'h2211);

    // Randomised frames against the model.
    rand_pc = 1'b1;
    gap_max = 3;
    for (int f = 0; f < 40; f++) begin
      int n, s, abort_at;
      logic [7:0] b, hi;
      fq.delete();
      repeat ($urandom_range(0, 2)) begin
        b = 8'($urandom);
        if (b == 8'h55) b = 8'h56;
        fq.push_back(b);
      end
      fq.push_back(8'h55);
      n = $urandom_range(1, 24);
      hi = 8'($urandom) & 8'hF8;
      fq.push_back(8'(n));
      fq.push_back(hi);
      s = n + int'(hi);
      for (int i = 0; i < 2 * n; i++) begin
        b = 8'($urandom);
        s += int'(b);
        fq.push_back(b);
      end
      if ($urandom_range(0, 2) != 0) fq.push_back(8'(256 - (s % 256)));
      else fq.push_back(8'(256 - (s % 256) + $urandom_range(1, 255)));
      abort_at = ($urandom_range(0, 5) == 0) ? $urandom_range(0, fq.size() - 1) : -1;
      boot_mode = 1'b1; cyc();
      foreach (fq[i]) begin
        if (i == abort_at) break;
        send(fq[i]);
      end
      if (abort_at < 0) begin
        repeat ($urandom_range(1, 3)) cyc();
        send(8'($urandom));
      end
      boot_mode = 1'b0;
      repeat ($urandom_range(1, 3)) cyc();
      send(8'($urandom));
      repeat (8) cyc();
    end
    rand_pc = 1'b0;
    repeat (2) cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
